// File: rtl/seq_det_pkg.sv
// Shared helpers for the serial pattern detector: KMP automaton transition and self-overlap length,
// evaluated at elaboration time only.
package seq_det_pkg;

    localparam int MaxPatW = 32;

    function automatic int state_w(input int pat_w);
        return (pat_w < 2) ? 1 : $clog2(pat_w);
    endfunction

    // Longest prefix of the pattern that is a suffix of (prefix of length s) followed by b.
    // Returns pat_w on a full match.
    function automatic int next_state(input logic [MaxPatW-1:0] pattern, input int pat_w,
                                      input int s, input logic b);
        int       res;
        int       m;
        logic     ok;
        logic     c;
        logic [4:0] ip;
        logic [4:0] ic;
        res = 0;
        for (int k = 1; k <= MaxPatW; k++) begin
            if (k <= s + 1 && k <= pat_w) begin
                ok = 1'b1;
                for (int j = 0; j < MaxPatW; j++) begin
                    if (j < k) begin
                        m  = s + 1 - k + j;
                        ic = 5'(pat_w - 1 - m);
                        c  = (m < s) ? pattern[ic] : b;
                        ip = 5'(pat_w - 1 - j);
                        if (pattern[ip] != c) ok = 1'b0;
                    end
                end
                if (ok) res = k;
            end
        end
        return res;
    endfunction

    // Longest proper border: prefix that is also a suffix of the whole pattern.
    function automatic int border_len(input logic [MaxPatW-1:0] pattern, input int pat_w);
        int       res;
        logic     ok;
        logic [4:0] ip;
        logic [4:0] is;
        res = 0;
        for (int k = 1; k < MaxPatW; k++) begin
            if (k < pat_w) begin
                ok = 1'b1;
                for (int j = 0; j < MaxPatW; j++) begin
                    if (j < k) begin
                        ip = 5'(pat_w - 1 - j);
                        is = 5'(k - 1 - j);
                        if (pattern[ip] != pattern[is]) ok = 1'b0;
                    end
                end
                if (ok) res = k;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seq_pattern_detector_sat_counter.sv
// Saturating up-counter with synchronous clear; used for the optional match counter.
module sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/seq_pattern_detector.sv
// Serial KMP pattern detector with Mealy match y and registered y_q.
// Optional saturating match counter enabled by defining SEQ_DET_MATCH_CNT_EN.
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter int unsigned      PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter bit               OVERLAP = 1'b1,
    parameter int unsigned      CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             x,
    input  logic             clear,
    output logic             y,
    output logic             y_q
`ifdef SEQ_DET_MATCH_CNT_EN
    ,
    output logic [CNT_W-1:0] match_count
`endif
);

    localparam int StW       = state_w(int'(PAT_W));
    localparam int Border    = border_len(MaxPatW'(PATTERN), int'(PAT_W));
    localparam int MatchNext = OVERLAP ? Border : 0;

    typedef logic [StW-1:0] state_t;

    localparam state_t LastS = state_t'(PAT_W - 1);

    state_t tab0 [PAT_W];
    state_t tab1 [PAT_W];
    state_t state_q;
    state_t state_d;

    // A full match maps to the overlap state instead of an out-of-range length.
    for (genvar gs = 0; gs < PAT_W; gs++) begin : g_tab
        localparam int N0 = next_state(MaxPatW'(PATTERN), int'(PAT_W), gs, 1'b0);
        localparam int N1 = next_state(MaxPatW'(PATTERN), int'(PAT_W), gs, 1'b1);
        assign tab0[gs] = state_t'((N0 >= int'(PAT_W)) ? MatchNext : N0);
        assign tab1[gs] = state_t'((N1 >= int'(PAT_W)) ? MatchNext : N1);
    end

    always_comb begin
        state_d = state_q;
        y       = 1'b0;
        if (clear) begin
            state_d = '0;
        end else if (in_valid) begin
            state_d = x ? tab1[state_q] : tab0[state_q];
            y       = (state_q == LastS) && (x == PATTERN[0]) && !reset;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= '0;
            y_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y;
        end
    end

`ifdef SEQ_DET_MATCH_CNT_EN
    sat_counter #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (y),
        .clr  (clear),
        .count(match_count)
    );
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed bench: three detectors (1011 overlap, 1011 non-overlap, 1111 overlap) share stimulus;
// a sliding-window model feeds a queue of expected matches checked each cycle.
module tb_seq_pattern_detector;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       x;
    logic       clear;
    logic [2:0] y_w;
    logic [2:0] yq_w;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [2:0] y;
    } exp_t;

    exp_t       q[$];
    logic [3:0] m_pat [3] = '{4'b1011, 4'b1011, 4'b1111};
    bit         m_ovl [3] = '{1'b1, 1'b0, 1'b1};
    logic [3:0] hist  [3];
    int         len   [3];
    logic [2:0] exp_yq;

`ifdef SEQ_DET_MATCH_CNT_EN
    logic [1:0] cnt_w;
    logic [7:0] cnt1_w;
    logic [7:0] cnt2_w;
    int         exp_cnt;
`endif

    always #5 clk = ~clk;

    seq_pattern_detector #(
        .PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)
    ) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .x(x), .clear(clear),
        .y(y_w[0]), .y_q(yq_w[0])
`ifdef SEQ_DET_MATCH_CNT_EN
        , .match_count(cnt_w)
`endif
    );

    seq_pattern_detector #(
        .PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)
    ) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .x(x), .clear(clear),
        .y(y_w[1]), .y_q(yq_w[1])
`ifdef SEQ_DET_MATCH_CNT_EN
        , .match_count(cnt1_w)
`endif
    );

    seq_pattern_detector #(
        .PAT_W(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .CNT_W(8)
    ) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .x(x), .clear(clear),
        .y(y_w[2]), .y_q(yq_w[2])
`ifdef SEQ_DET_MATCH_CNT_EN
        , .match_count(cnt2_w)
`endif
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            hist[i] = '0;
            len[i]  = 0;
        end
        exp_yq = '0;
`ifdef SEQ_DET_MATCH_CNT_EN
        exp_cnt = 0;
`endif
    endtask

    // Called just after a rising edge; leaves just after the next one.
    task automatic step(input string tag, input logic v, input logic xb, input logic c);
        exp_t e;
        in_valid = v;
        x        = xb;
        clear    = c;
        for (int i = 0; i < 3; i++) begin
            e.y[i] = v && !c && (len[i] >= 3) && ({hist[i][2:0], xb} == m_pat[i]);
        end
        q.push_back(e);
        @(negedge clk);
        e = q.pop_front();
        check({tag, " y"}, {5'd0, y_w}, {5'd0, e.y});
        check({tag, " y_q"}, {5'd0, yq_w}, {5'd0, exp_yq});
`ifdef SEQ_DET_MATCH_CNT_EN
        check({tag, " cnt"}, {6'd0, cnt_w}, 8'(exp_cnt));
        if (c) exp_cnt = 0;
        else if (e.y[0] && exp_cnt < 3) exp_cnt++;
`endif
        for (int i = 0; i < 3; i++) begin
            if (c) begin
                hist[i] = '0;
                len[i]  = 0;
            end else if (v) begin
                if (e.y[i] && !m_ovl[i]) begin
                    hist[i] = '0;
                    len[i]  = 0;
                end else begin
                    hist[i] = {hist[i][2:0], xb};
                    if (len[i] < 3) len[i]++;
                end
            end
        end
        exp_yq = e.y;
        @(posedge clk);
        #1;
    endtask

    task automatic bits(input string tag, input logic [15:0] b, input int n);
        for (int i = n - 1; i >= 0; i--) step(tag, 1'b1, b[i], 1'b0);
    endtask

    // Asynchronous reset pulse between edges; outputs must drop without a clock.
    task automatic reset_pulse(input string tag);
        in_valid = 1'b0;
        clear    = 1'b0;
        #1;
        check({tag, " y_q pre"}, {5'd0, yq_w}, {5'd0, exp_yq});
        #1;
        reset = 1'b1;
        #1;
        check({tag, " y_q async"}, {5'd0, yq_w}, 8'd0);
`ifdef SEQ_DET_MATCH_CNT_EN
        check({tag, " cnt async"}, {6'd0, cnt_w}, 8'd0);
`endif
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b1;
        x        = 1'b1;
        clear    = 1'b0;
        model_reset();
        #12;
        check("reset y", {5'd0, y_w}, 8'd0);
        check("reset y_q", {5'd0, yq_w}, 8'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        bits("t1", 16'b1011, 4);
        step("t1 idle", 1'b0, 1'b0, 1'b0);

        step("t2 clr", 1'b1, 1'b1, 1'b1);
        bits("t2", 16'b1011011, 7);

        step("t3 clr", 1'b0, 1'b0, 1'b1);
        step("t3", 1'b1, 1'b1, 1'b0);
        step("t3 gap", 1'b0, 1'b1, 1'b0);
        step("t3 gap", 1'b0, 1'b0, 1'b0);
        step("t3", 1'b1, 1'b0, 1'b0);
        step("t3 gap", 1'b0, 1'b1, 1'b0);
        step("t3", 1'b1, 1'b1, 1'b0);
        step("t3 gap", 1'b0, 1'b0, 1'b0);
        step("t3 gap", 1'b0, 1'b1, 1'b0);
        step("t3", 1'b1, 1'b1, 1'b0);
        step("t3 idle", 1'b0, 1'b0, 1'b0);

        step("t4 clr", 1'b0, 1'b0, 1'b1);
        bits("t4", 16'b101, 3);
        step("t4 clr", 1'b1, 1'b1, 1'b1);
        bits("t4", 16'b1011, 4);
        step("t4 idle", 1'b0, 1'b0, 1'b0);

        bits("t5a", 16'b1011, 4);
        reset_pulse("t5a");
        bits("t5b", 16'b101, 3);
        reset_pulse("t5b");
        bits("t5b", 16'b11011, 5);
        step("t5 idle", 1'b0, 1'b0, 1'b0);

        step("t6 clr", 1'b0, 1'b0, 1'b1);
        bits("t6", 16'b1011011011011011, 16);
        step("t6 idle", 1'b0, 1'b0, 1'b0);
        step("t6 clr", 1'b1, 1'b1, 1'b1);
        step("t6 after", 1'b0, 1'b0, 1'b0);

        bits("t7 ones", 16'b111111, 6);
        step("t7 idle", 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
